// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: converts a cmd/rsp handshake into one AXI write or read,
// with a sticky watchdog that flags a slave that stops responding.
module axi_lite_cmd_master #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                            axi_aclk,
   input  logic                            axi_areset,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_we,
   input  logic [C_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic                            rsp_we,
   output logic [C_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic                            busy,
   output logic                            timeout_err,
   output logic [C_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
   output logic                            axi_awvalid,
   input  logic                            axi_awready,
   output logic [C_AXI_DATA_WIDTH-1:0]     axi_wdata,
   output logic [C_AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
   output logic                            axi_wvalid,
   input  logic                            axi_wready,
   input  logic [1:0]                      axi_bresp,
   input  logic                            axi_bvalid,
   output logic                            axi_bready,
   output logic [C_AXI_ADDR_WIDTH-1:0]     axi_araddr,
   output logic                            axi_arvalid,
   input  logic                            axi_arready,
   input  logic [C_AXI_DATA_WIDTH-1:0]     axi_rdata,
   input  logic [1:0]                      axi_rresp,
   input  logic                            axi_rvalid,
   output logic                            axi_rready
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_REQ  = 3'd3;
   localparam logic [2:0] RD_RESP = 3'd4;
   localparam logic [2:0] RSP     = 3'd5;

   logic [2:0]       state;
   logic             aw_done;
   logic             w_done;
   logic             aw_fin;
   logic             w_fin;
   logic             waiting;
   logic [CNT_W-1:0] wd_cnt;

   // A request channel counts as finished once its handshake happened now or earlier.
   assign aw_fin  = aw_done | (axi_awvalid & axi_awready);
   assign w_fin   = w_done | (axi_wvalid & axi_wready);
   assign waiting = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state       <= IDLE;
         cmd_ready   <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         wd_cnt      <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_we      <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= 2'b00;
         axi_awaddr  <= '0;
         axi_awvalid <= 1'b0;
         axi_wdata   <= '0;
         axi_wstrb   <= '0;
         axi_wvalid  <= 1'b0;
         axi_bready  <= 1'b0;
         axi_araddr  <= '0;
         axi_arvalid <= 1'b0;
         axi_rready  <= 1'b0;
      end else begin
         // Watchdog keeps counting while waiting on the slave; every transition below clears it.
         if (waiting && wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + CNT_W'(1);
         if (waiting && wd_cnt == CNT_LAST) timeout_err <= 1'b1;

         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  wd_cnt    <= '0;
                  if (cmd_we) begin
                     axi_awaddr  <= cmd_addr;
                     axi_wdata   <= cmd_wdata;
                     axi_wstrb   <= cmd_wstrb;
                     axi_awvalid <= 1'b1;
                     axi_wvalid  <= 1'b1;
                     state       <= WR_REQ;
                  end else begin
                     axi_araddr  <= cmd_addr;
                     axi_arvalid <= 1'b1;
                     state       <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
               if (axi_wvalid && axi_wready) axi_wvalid <= 1'b0;
               if (aw_fin && w_fin) begin
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
                  axi_bready <= 1'b1;
                  wd_cnt     <= '0;
                  state      <= WR_RESP;
               end else begin
                  aw_done <= aw_fin;
                  w_done  <= w_fin;
               end
            end
            WR_RESP: begin
               if (axi_bvalid && axi_bready) begin
                  axi_bready <= 1'b0;
                  rsp_resp   <= axi_bresp;
                  rsp_rdata  <= '0;
                  rsp_we     <= 1'b1;
                  rsp_valid  <= 1'b1;
                  wd_cnt     <= '0;
                  state      <= RSP;
               end
            end
            RD_REQ: begin
               if (axi_arvalid && axi_arready) begin
                  axi_arvalid <= 1'b0;
                  axi_rready  <= 1'b1;
                  wd_cnt      <= '0;
                  state       <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (axi_rvalid && axi_rready) begin
                  axi_rready <= 1'b0;
                  rsp_resp   <= axi_rresp;
                  rsp_rdata  <= axi_rdata;
                  rsp_we     <= 1'b0;
                  rsp_valid  <= 1'b1;
                  wd_cnt     <= '0;
                  state      <= RSP;
               end
            end
            RSP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  wd_cnt    <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
